axi_wr_arbiter: RTL
===================

// Module: axi_wr_arbiter
// PURPOSE
//  Shares the single AXI4 write master port (AW/W/B) between two internal write requesters.
//  Sits between the compute/DRAM-side writers and the top-level *_m_inf write pins.
//  Serializes one full burst at a time: AW -> all W beats -> B, then releases the port.
//  Round-robin arbitration by default.
// PARAMETERS
//  ID_WIDTH    4   AXI ID width; awid = granted requester index, zero-extended
//  ADDR_WIDTH  32  address width
//  DATA_WIDTH  32  data width; awsize fixed 3'b010 (4 bytes)
// PORTS
//  clk            in   1             single clock, all logic rising-edge
//  rst            in   1             synchronous, active-high reset
//  req_valid      in   2             per-requester burst request
//  req_ready      out  2             one-hot grant/accept pulse (combinational in IDLE)
//  req_addr       in   2*ADDR_WIDTH  per-requester start address, [ADDR_WIDTH*i +: ADDR_WIDTH]
//  req_len        in   2*4           per-requester beats-1 (0..15)
//  req_wdata      in   2*DATA_WIDTH  per-requester write data stream
//  req_wvalid     in   2             per-requester data valid
//  req_wready     out  2             data ready; only the granted bit may be 1
//  req_done       out  2             1-cycle pulse on B handshake, granted bit only
//  req_bresp      out  2             BRESP captured at last completion (shared, held)
//  awid_m_inf     out  ID_WIDTH      write address ID
//  awaddr_m_inf   out  ADDR_WIDTH    write address
//  awsize_m_inf   out  3             constant 3'b010
//  awburst_m_inf  out  2             constant 2'b01 (INCR)
//  awlen_m_inf    out  4             burst length - 1
//  awvalid_m_inf  out  1             address valid
//  awready_m_inf  in   1             address ready
//  wdata_m_inf    out  DATA_WIDTH    write data
//  wlast_m_inf    out  1             last beat
//  wvalid_m_inf   out  1             data valid
//  wready_m_inf   in   1             data ready
//  bid_m_inf      in   ID_WIDTH      response ID (ignored, ordering is strict)
//  bresp_m_inf    in   2             response code
//  bvalid_m_inf   in   1             response valid
//  bready_m_inf   out  1             response ready
// BEHAVIOUR
//  Reset: FSM=IDLE, rr pointer=0 (req0 favoured), all outputs 0 except awsize/awburst constants.
//  FSM IDLE -> AW -> W -> B -> IDLE.
//  IDLE: if any req_valid, winner = pointer's requester if valid, else the other.
//   req_ready[winner]=1 this cycle; latch addr/len/id; next state AW.
//  AW: awvalid=1 (registered) from cycle after grant; addr/len/id held stable until awready.
//   awvalid && awready -> W; beat counter cleared to 0.
//  W: wvalid = req_wvalid[g]; wdata = req_wdata[g]; req_wready[g] = wready_m_inf.
//   wlast = (cnt == len). Counter increments on wvalid && wready.
//   Last-beat handshake -> B. No W before AW handshake.
//  B: bready=1. On bvalid: req_done[g]=1 for one cycle, req_bresp<=bresp, pointer<=~g, -> IDLE.
//  Minimum latency: grant->AW 1 cycle; len=0 burst with zero-wait slave = 4 cycles IDLE..IDLE.
//  Non-granted requester: req_ready/req_wready/req_done held 0; its req_valid may stay high.
//  Simultaneous req in IDLE: pointer decides; after each completion the loser gets next grant.
//  Requester drops req_valid after grant: ignored, burst completes with latched addr/len.
//  bresp != OKAY: reported on req_bresp; no retry.
//  4 KB boundary legality is the requester's responsibility; no splitting.
//  rst mid-burst: all outputs 0 next edge, FSM=IDLE, pointer=0; outstanding B is dropped.
// CONFIGURATION
//  WR_ARB_FIXED_PRIO_EN defined: fixed priority, req0 always wins a tie; pointer logic removed.
//  Undefined (default): round-robin as above.
// TESTING
//  1 req0 only, addr 0x1000, len 3, zero-wait slave -> awid 0, awlen 3, 4 beats, wlast on beat 4, done[0].
//  2 req0+req1 both valid at reset -> req0 served first, then req1.
//    With both re-requesting: grants alternate 0,1,0,1.
//    With WR_ARB_FIXED_PRIO_EN: 0,0,0.
//  3 awready delayed 5 cycles, len 0 -> awvalid/addr stable 6 cycles; wvalid not asserted before handshake.
//  4 wready toggling, len 15 -> exactly 16 beats in order; wlast only with beat 16.
//    req_wready[1]=0 throughout a req0 burst.
//  5 bvalid with bresp 2'b10 after 3 cycles -> bready held; done pulse 1 cycle; req_bresp=2'b10.
//  6 rst=1 during W beat 2 of len 7 -> next cycle awvalid/wvalid/bready/req_ready=0, FSM IDLE.
//    A new req0 is then granted normally.

Source files
------------

// File: rtl/axi_wr_arbiter.sv
// axi_wr_arbiter: two-requester AXI4 write-port arbiter, one burst (AW, W beats, B) at a time, round-robin unless WR_ARB_FIXED_PRIO_EN
module axi_wr_arbiter #(
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              req_valid,
  output logic [1:0]              req_ready,
  input  logic [2*ADDR_WIDTH-1:0] req_addr,
  input  logic [7:0]              req_len,
  input  logic [2*DATA_WIDTH-1:0] req_wdata,
  input  logic [1:0]              req_wvalid,
  output logic [1:0]              req_wready,
  output logic [1:0]              req_done,
  output logic [1:0]              req_bresp,
  output logic [ID_WIDTH-1:0]     awid_m_inf,
  output logic [ADDR_WIDTH-1:0]   awaddr_m_inf,
  output logic [2:0]              awsize_m_inf,
  output logic [1:0]              awburst_m_inf,
  output logic [3:0]              awlen_m_inf,
  output logic                    awvalid_m_inf,
  input  logic                    awready_m_inf,
  output logic [DATA_WIDTH-1:0]   wdata_m_inf,
  output logic                    wlast_m_inf,
  output logic                    wvalid_m_inf,
  input  logic                    wready_m_inf,
  input  logic [ID_WIDTH-1:0]     bid_m_inf,
  input  logic [1:0]              bresp_m_inf,
  input  logic                    bvalid_m_inf,
  output logic                    bready_m_inf
);
  typedef enum logic [1:0] {IDLE, AW, W, B} state_t;
  state_t state, nxt;
  logic g, win, any;
  logic [ADDR_WIDTH-1:0] addr;
  logic [3:0] len, cnt;
  logic unused_bid;
  assign unused_bid = ^bid_m_inf;
  assign any = |req_valid;
`ifdef WR_ARB_FIXED_PRIO_EN
  assign win = ~req_valid[0];
`else
  logic ptr;
  assign win = req_valid[ptr] ? ptr : ~ptr;
  always_ff @(posedge clk)
    if (rst) ptr <= 1'b0;
    else if (state == B && bvalid_m_inf) ptr <= ~g;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      g         <= 1'b0;
      addr      <= '0;
      len       <= '0;
      cnt       <= '0;
      req_bresp <= '0;
    end else begin
      state <= nxt;
      if (state == IDLE && any) begin
        g    <= win;
        addr <= win ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : req_addr[ADDR_WIDTH-1:0];
        len  <= win ? req_len[7:4] : req_len[3:0];
      end
      cnt <= state == AW ? '0 : (wvalid_m_inf && wready_m_inf) ? cnt + 4'd1 : cnt;
      if (state == B && bvalid_m_inf) req_bresp <= bresp_m_inf;
    end
  end
  always_comb begin
    nxt = state;
    case (state)
      IDLE: nxt = any ? AW : IDLE;
      AW:   nxt = awready_m_inf ? W : AW;
      W:    nxt = (wvalid_m_inf && wready_m_inf && wlast_m_inf) ? B : W;
      B:    nxt = bvalid_m_inf ? IDLE : B;
      default: nxt = IDLE;
    endcase
  end
  assign awid_m_inf    = ID_WIDTH'(g);
  assign awaddr_m_inf  = addr;
  assign awlen_m_inf   = len;
  assign awsize_m_inf  = 3'b010;
  assign awburst_m_inf = 2'b01;
  assign awvalid_m_inf = state == AW;
  assign wvalid_m_inf  = state == W && (g ? req_wvalid[1] : req_wvalid[0]);
  assign wdata_m_inf   = state != W ? '0 : g ? req_wdata[2*DATA_WIDTH-1:DATA_WIDTH] : req_wdata[DATA_WIDTH-1:0];
  assign wlast_m_inf   = state == W && cnt == len;
  assign bready_m_inf  = state == B;
  assign req_ready     = (state == IDLE && any && !rst) ? (win ? 2'b10 : 2'b01) : 2'b00;
  assign req_wready    = (state == W && wready_m_inf) ? (g ? 2'b10 : 2'b01) : 2'b00;
  assign req_done      = (state == B && bvalid_m_inf) ? (g ? 2'b10 : 2'b01) : 2'b00;
endmodule
